// File: rtl/cpu_defines.sv
// cpu_defines: shared divider state encoding, iteration count and MIPS funct codes
package cpu_defines;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_e;
    localparam int DIV_CYCLES = 32;
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU = 6'b011011;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring iteration on {rem,quot}
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quot_next
);
    logic [WIDTH:0] shifted;
    logic           ge;
    assign shifted   = {rem, quot[WIDTH-1]};
    assign ge        = shifted >= {1'b0, divisor};
    // a successful trial always fits in WIDTH bits, so modular subtraction is exact
    assign rem_next  = ge ? shifted[WIDTH-1:0] - divisor : shifted[WIDTH-1:0];
    assign quot_next = {quot[WIDTH-2:0], ge};
endmodule

// File: rtl/div_stall_unit.sv
// div_stall_unit: multi-cycle DIV/DIVU for the execute stage; stalls the pipeline while iterating
module div_stall_unit import cpu_defines::*; #(
    parameter int WIDTH      = 32,
    parameter int DIV_CYCLES = cpu_defines::DIV_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_startE,
    input  logic             div_signedE,
    input  logic             annulE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    output logic             stall_divE,
    output logic             div_validE,
    output logic [WIDTH-1:0] div_hiE,
    output logic [WIDTH-1:0] div_loE
);
    localparam int CW = $clog2(DIV_CYCLES);
    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quot_q, quot_d, dvsr_q, dvsr_d;
    logic [WIDTH-1:0] araw_q, araw_d, hi_q, hi_d, lo_q, lo_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic [WIDTH-1:0] rem_nx, quot_nx, a_abs, b_abs;
    logic             last;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quot     (quot_q),
        .divisor  (dvsr_q),
        .rem_next (rem_nx),
        .quot_next(quot_nx)
    );

    assign a_abs      = (div_signedE & srcaE[WIDTH-1]) ? -srcaE : srcaE;
    assign b_abs      = (div_signedE & srcbE[WIDTH-1]) ? -srcbE : srcbE;
    assign last       = cnt_q == CW'(DIV_CYCLES - 1);
    assign stall_divE = ~annulE & ((state_q == IDLE & div_startE) | state_q == BUSY);
    assign div_validE = ~annulE & state_q == DONE;
    assign div_hiE    = hi_q;
    assign div_loE    = lo_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        dvsr_d  = dvsr_q;
        araw_d  = araw_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        if (annulE) begin
            state_d = IDLE;
        end else if (state_q == IDLE && div_startE) begin
            state_d = BUSY;
            cnt_d   = '0;
            rem_d   = '0;
            quot_d  = a_abs;
            dvsr_d  = b_abs;
            araw_d  = srcaE;
            qneg_d  = div_signedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
            rneg_d  = div_signedE & srcaE[WIDTH-1];
            dz_d    = srcbE == '0;
        end else if (state_q == BUSY) begin
            rem_d  = rem_nx;
            quot_d = quot_nx;
            cnt_d  = cnt_q + 1'b1;
            // results are captured on the final step so they appear in DONE and hold afterwards
            if (last) begin
                state_d = DONE;
                lo_d    = dz_q ? '1 : qneg_q ? -quot_nx : quot_nx;
                hi_d    = dz_q ? araw_q : rneg_q ? -rem_nx : rem_nx;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            dvsr_q  <= '0;
            araw_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            dvsr_q  <= dvsr_d;
            araw_q  <= araw_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end
endmodule

// File: tb/tb_div_stall_unit.sv
// tb_div_stall_unit: directed vectors, corner sequences and random divides against an arithmetic model
module tb_div_stall_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        div_startE = 1'b0;
    logic        div_signedE = 1'b0;
    logic        annulE = 1'b0;
    logic [31:0] srcaE = '0;
    logic [31:0] srcbE = '0;
    logic        stall_divE, div_validE;
    logic [31:0] div_hiE, div_loE;
    int          n_cmp = 0;
    int          n_fail = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sg;
        logic [31:0] lo;
        logic [31:0] hi;
        string       nm;
    } vec_t;
    vec_t vecs[7];

    div_stall_unit dut (
        .clk        (clk),
        .rst        (rst),
        .div_startE (div_startE),
        .div_signedE(div_signedE),
        .annulE     (annulE),
        .srcaE      (srcaE),
        .srcbE      (srcbE),
        .stall_divE (stall_divE),
        .div_validE (div_validE),
        .div_hiE    (div_hiE),
        .div_loE    (div_loE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sg,
                                  output logic [31:0] lo, output logic [31:0] hi);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else if (!sg) begin
            lo = a / b;
            hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo = 32'h8000_0000;
            hi = 0;
        end else begin
            lo = 32'(sa / sb);
            hi = 32'(sa % sb);
        end
    endfunction

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                           input logic [31:0] elo, input logic [31:0] ehi, input string nm);
        int ns;
        bit seen;
        @(posedge clk);
        #1;
        div_startE  = 1'b1;
        div_signedE = sg;
        srcaE       = a;
        srcbE       = b;
        ns   = 0;
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (div_validE) seen = 1;
            else if (stall_divE) ns++;
        end
        chk({nm, " valid"}, 32'(seen), 32'd1);
        chk({nm, " stall_cycles"}, 32'(ns), 32'd33);
        chk({nm, " stall_in_done"}, 32'(stall_divE), 32'd0);
        chk({nm, " lo"}, div_loE, elo);
        chk({nm, " hi"}, div_hiE, ehi);
    endtask

    task automatic idle_after(input string nm);
        logic [31:0] l, h;
        l = div_loE;
        h = div_hiE;
        @(posedge clk);
        #1;
        div_startE = 1'b0;
        @(negedge clk);
        chk({nm, " idle_stall"}, 32'(stall_divE), 32'd0);
        chk({nm, " idle_valid"}, 32'(div_validE), 32'd0);
        chk({nm, " hold_lo"}, div_loE, l);
        chk({nm, " hold_hi"}, div_hiE, h);
    endtask

    initial begin
        logic [31:0] a, b, elo, ehi;
        logic        sg;
        int          viol;
        vecs[0] = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, "divu_100_7"};
        vecs[1] = '{32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_m7_2"};
        vecs[2] = '{32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, "div_7_m2"};
        vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, "div_min_m1"};
        vecs[4] = '{32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, "divu_5_0"};
        vecs[5] = '{32'hFFFF_FFF7, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF7, "div_m9_0"};
        vecs[6] = '{32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, "divu_max_1"};

        #2 rst = 1'b1;
        #10;
        chk("reset stall", 32'(stall_divE), 32'd0);
        chk("reset valid", 32'(div_validE), 32'd0);
        chk("reset hi", div_hiE, 32'd0);
        chk("reset lo", div_loE, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].sg, vecs[i].lo, vecs[i].hi, vecs[i].nm);
            idle_after(vecs[i].nm);
        end

        // flush mid-divide while start is still held
        @(posedge clk);
        #1;
        div_startE = 1'b1;
        div_signedE = 1'b0;
        srcaE = 32'd100;
        srcbE = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        annulE = 1'b1;
        #1;
        chk("annul stall_drop", 32'(stall_divE), 32'd0);
        chk("annul valid", 32'(div_validE), 32'd0);
        @(posedge clk);
        #1;
        annulE = 1'b0;
        div_startE = 1'b0;
        @(negedge clk);
        chk("annul idle_stall", 32'(stall_divE), 32'd0);
        viol = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (div_validE || stall_divE) viol++;
        end
        chk("annul no_result", 32'(viol), 32'd0);
        run_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, "divu_9_3");
        idle_after("divu_9_3");

        // asynchronous reset between edges mid-divide
        @(posedge clk);
        #1;
        div_startE = 1'b1;
        srcaE = 32'd1000;
        srcbE = 32'd3;
        repeat (5) @(posedge clk);
        #3;
        div_startE = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst stall", 32'(stall_divE), 32'd0);
        chk("async_rst valid", 32'(div_validE), 32'd0);
        chk("async_rst hi", div_hiE, 32'd0);
        chk("async_rst lo", div_loE, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div(32'd1, 32'd1, 1'b0, 32'd1, 32'd0, "b2b_1_1");
        run_div(32'd8, 32'd2, 1'b0, 32'd4, 32'd0, "b2b_8_2");
        idle_after("b2b_8_2");

        for (int i = 0; i < 24; i++) begin
            a  = $urandom;
            sg = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = -($urandom_range(1, 15));
                default: b = $urandom >> $urandom_range(0, 28);
            endcase
            model(a, b, sg, elo, ehi);
            run_div(a, b, sg, elo, ehi, $sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 1) idle_after($sformatf("rand%0d", i));
        end
        idle_after("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/div_stall_unit.md
Name: div_stall_unit

Overview:
- Multi-cycle 32-bit radix-2 restoring divider in the execute stage (DIV/DIVU).
- Stall initiator: raises stall_divE toward the hazard unit, which freezes F/D/E and bubbles M while the divide runs.
- On completion, presents hi (remainder) and lo (quotient) for one cycle alongside the still-held E-stage instruction, for the HILO write path.

Parameters:
WIDTH, 32, operand/result width
DIV_CYCLES, 32, iteration count (must equal WIDTH)

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
div_startE  in  1  E-stage instruction is DIV/DIVU; held high by pipeline while stalled
div_signedE  in  1  1 = DIV (signed), 0 = DIVU
annulE  in  1  exception/flush of E-stage instruction; aborts operation
srcaE  in  32  dividend (rs)
srcbE  in  32  divisor (rt)
stall_divE  out  1  stall request to hazard unit
div_validE  out  1  result valid, one cycle
div_hiE  out  32  remainder
div_loE  out  32  quotient

Behaviour:
- States: IDLE, BUSY, DONE. Reset (async, rst=1) -> IDLE; counter=0; internal regs=0; div_validE=0, div_hiE=0, div_loE=0, stall_divE=0.
- stall_divE (combinational) = ~annulE & ((IDLE & div_startE) | BUSY).
- IDLE, div_startE=1, annulE=0 (cycle 0):
  - latch |srcaE| and |srcbE| when signed, raw values when unsigned;
  - record quotient sign = sign(a)^sign(b) and remainder sign = sign(a);
  - flag divide-by-zero (srcbE==0); clear remainder accumulator and counter; go to BUSY.
- BUSY (cycles 1..32): one restoring step per cycle:
  - shift {rem,quot} left 1;
  - trial = rem - divisor (33-bit);
  - if non-negative: rem = trial, quot LSB = 1.
  - counter increments; after the step with counter==DIV_CYCLES-1, go to DONE.
- DONE (cycle 33): stall_divE=0, div_validE=1; div_hiE/div_loE show sign-corrected results. Unconditionally -> IDLE at the next edge.
  - div_startE is still high in this cycle (instruction leaving E) and is ignored. No restart.
- Total: stall asserted cycles 0..32 (33 cycles); result on cycle 33; pipeline advances at end of cycle 33.
- Sign correction (signed only):
  - lo negated if quotient sign=1;
  - hi negated if remainder sign=1;
  - -2^31 / -1 yields lo=32'h8000_0000, hi=0 (natural wrap, no trap).
- Divide-by-zero:
  - fixed latency retained;
  - result forced to lo=32'hFFFF_FFFF, hi=original srcaE, regardless of signedness.
- div_hiE/div_loE hold their last value outside DONE; only div_validE qualifies them.
- annulE=1 in any state:
  - stall_divE drops combinationally;
  - next edge -> IDLE, div_validE=0 next cycle;
  - no result is produced. annulE in DONE suppresses div_validE in that cycle.
- Back-to-back divides: a new div_startE in the cycle after DONE (state IDLE) starts a fresh operation normally.
- rst mid-BUSY: immediate IDLE, all outputs 0.

Decomposition:
- Shared package (cpu_defines):
  - DIV state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10);
  - DIV_CYCLES constant;
  - funct codes DIV/DIVU, which the decoder also uses.
- Sub-module div_step: purely combinational single restoring iteration (inputs rem, quot, divisor; outputs next rem/quot). Instantiated once in the top-level module, which holds the registers, counter and FSM.

Test Plan:
- DIVU 100/7: start held -> stall_divE=1 for exactly 33 cycles; cycle 33 div_validE=1, lo=14, hi=2, stall=0.
- DIV -7/2 signed -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1). DIV 7/-2 -> lo=-3, hi=1.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF -> lo=32'h8000_0000, hi=0. DIVU 5/0 -> lo=32'hFFFF_FFFF, hi=5, latency unchanged.
- annulE pulsed at cycle 10 of BUSY -> stall_divE=0 same cycle, IDLE next cycle, div_validE never asserts. A following DIVU 9/3 gives lo=3, hi=0.
- rst asserted asynchronously mid-BUSY (between edges) -> outputs 0 immediately, IDLE. Back-to-back DIVU 1/1 then DIVU 8/2 -> two results, 33-cycle stall each, DONE start never retriggers.
